// File: rtl/wb_arbiter_if.sv
// Pipelined 16-bit Wishbone port bundle.
// master drives the request, slave returns ack/stall/data.
interface wb_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with outstanding tracking
// and optional burst-limit preemption.
module wb_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_MAX       = 16
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   m0,
    wb_arbiter_if.slave   m1,
    wb_arbiter_if.master  s
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    burst_q, burst_d;

    logic own_cyc, own_stb, oth_cyc;
    logic full, preempt;
    logic stb_o, accept, ack_ok, own_stall;

    // Owner selection, limit flags and the slave-side request mux.
    always_comb begin
        own_cyc = owner_q ? m1.cyc : m0.cyc;
        own_stb = owner_q ? m1.stb : m0.stb;
        oth_cyc = owner_q ? m0.cyc : m1.cyc;
        full    = (cnt_q == CNT_MAX);
        // Once the burst budget is spent and the peer waits, no new strobes.
        preempt = (BURST_MAX != 0) && (int'(burst_q) >= BURST_MAX) && oth_cyc;

        stb_o   = 1'b0;
        s.cyc   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.dat_w = '0;
        if (state_q != IDLE) begin
            s.cyc   = 1'b1;
            s.we    = owner_q ? m1.we : m0.we;
            s.adr   = owner_q ? m1.adr : m0.adr;
            s.dat_w = owner_q ? m1.dat_w : m0.dat_w;
            stb_o   = (state_q == OWN) && own_stb && !full && !preempt;
        end
        s.stb  = stb_o;
        accept = stb_o && !s.stall;
        ack_ok = s.ack && (state_q != IDLE) && (cnt_q != '0);
    end

    // Response routing: acks only to the owner, stalls to everyone else.
    always_comb begin
        own_stall = 1'b1;
        if (state_q == OWN) begin
            own_stall = s.stall | full | preempt;
        end
        m0.stall = m0.stb;
        m1.stall = m1.stb;
        if (state_q != IDLE) begin
            if (owner_q) begin
                m1.stall = own_stall;
            end else begin
                m0.stall = own_stall;
            end
        end
        m0.ack   = ack_ok && !owner_q;
        m1.ack   = ack_ok && owner_q;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
    end

    // Next-state: grant, abort, preemption and drain bookkeeping.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q + CW'(accept) - CW'(ack_ok);
        burst_d = burst_q;
        if (accept && burst_q != 8'hFF) begin
            burst_d = burst_q + 8'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (m0.cyc || m1.cyc) begin
                    owner_d = (m0.cyc && m1.cyc) ? ~last_q : m1.cyc;
                    state_d = OWN;
                    cnt_d   = '0;
                    burst_d = '0;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (preempt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0 || !own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; master 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
        end
    end
endmodule
